// File: rtl/cla_pkg.sv
// Shared types for the nibble-serial carry-look-ahead adder.
package cla_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} cla_state_t;
  typedef logic [NIBBLE_W-1:0] nibble_t;
endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-look-ahead adder; every carry is a flat
// sum of generate/propagate products rather than a ripple chain.
module cla4_slice
  import cla_pkg::*;
(
  input  nibble_t x,
  input  nibble_t y,
  input  logic    ci,
  output nibble_t s,
  output logic    co
);
  nibble_t p;
  nibble_t g;
  logic    c1;
  logic    c2;
  logic    c3;

  assign p = x ^ y;
  assign g = x & y;

  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c3, c2, c1, ci};
endmodule

// File: rtl/serial_cla_adder.sv
// WIDTH-bit adder that walks one nibble per clock through a single CLA
// slice, with valid/ready handshakes on the operand and result sides.
module serial_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int OFF_W = IDX_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);
  localparam logic [WIDTH-1:0] NIB_MASK = WIDTH'(4'hF);

  cla_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [OFF_W-1:0] bit_off;
  nibble_t          x_nib;
  nibble_t          y_nib;
  nibble_t          s_nib;
  logic             slice_co;

  // Shifting by the nibble offset avoids part-select index width issues
  // when NIB is 1.
  assign bit_off = {idx_q, 2'b00};
  assign x_nib   = nibble_t'(a_q >> bit_off);
  assign y_nib   = nibble_t'(b_q >> bit_off);

  cla4_slice u_slice (
    .x  (x_nib),
    .y  (y_nib),
    .ci (carry_q),
    .s  (s_nib),
    .co (slice_co)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = (sum_q & ~(NIB_MASK << bit_off)) | (WIDTH'(s_nib) << bit_off);
        carry_d = slice_co;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_co;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_cla_adder.sv
// Bench for serial_cla_adder: a 16-bit and a 4-bit instance, checked
// against plain integer addition.
module tb_serial_cla_adder;
  logic clk;

  logic        rst_n16, in_valid16, in_ready16, cin16;
  logic        out_valid16, out_ready16, cout16;
  logic [15:0] a16, b16, sum16;

  logic        rst_n4, in_valid4, in_ready4, cin4;
  logic        out_valid4, out_ready4, cout4;
  logic [3:0]  a4, b4, sum4;

  int n_cmp = 0;
  int n_bad = 0;

  serial_cla_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n16), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16),
    .out_ready(out_ready16), .sum(sum16), .cout(cout16)
  );

  serial_cla_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n4), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4),
    .out_ready(out_ready4), .sum(sum4), .cout(cout4)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {16'b0, c};
  endfunction

  function automatic logic [4:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {4'b0, c};
  endfunction

  // ---------------- drivers (no checking) ----------------
  task automatic start16(input logic [15:0] av, input logic [15:0] bv, input logic cv, output bit ok);
    int n = 0;
    while (in_ready16 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    ok = (in_ready16 === 1'b1);
    a16 = av; b16 = bv; cin16 = cv; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
  endtask

  task automatic wait16(output int lat);
    lat = 0;
    while (out_valid16 !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic ack16();
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
  endtask

  task automatic start4(input logic [3:0] av, input logic [3:0] bv, input logic cv, output bit ok);
    int n = 0;
    while (in_ready4 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    ok = (in_ready4 === 1'b1);
    a4 = av; b4 = bv; cin4 = cv; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
  endtask

  task automatic wait4(output int lat);
    lat = 0;
    while (out_valid4 !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic ack4();
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready16 !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready16: got %b expected 0", in_ready16); end
    n_cmp++; if (out_valid16 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid16: got %b expected 0", out_valid16); end
    n_cmp++; if ({cout16, sum16} !== 17'h0) begin n_bad++; $display("FAIL reset_sum16: got %h expected 0", {cout16, sum16}); end
    n_cmp++; if (in_ready4 !== 1'b0 || out_valid4 !== 1'b0 || {cout4, sum4} !== 5'h0) begin
      n_bad++; $display("FAIL reset_dut4: got rdy=%b vld=%b res=%h expected 0/0/0", in_ready4, out_valid4, {cout4, sum4});
    end
    rst_n16 = 1'b1; rst_n4 = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0) begin
      n_bad++; $display("FAIL post_reset16: got rdy=%b vld=%b expected 1/0", in_ready16, out_valid16);
    end
    n_cmp++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
      n_bad++; $display("FAIL post_reset4: got rdy=%b vld=%b expected 1/0", in_ready4, out_valid4);
    end
  endtask

  task automatic test_directed16();
    logic [15:0] ta [4] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0F0F};
    logic [15:0] tb [4] = '{16'h4321, 16'h0001, 16'h8000, 16'h00F1};
    logic        tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      bit ok; int lat; logic [16:0] exp;
      exp = ref16(ta[i], tb[i], tc[i]);
      start16(ta[i], tb[i], tc[i], ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL dir_accept[%0d]: got in_ready=0 expected 1", i); end
      wait16(lat);
      n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL dir_latency[%0d]: got %0d expected 4", i, lat); end
      n_cmp++; if ({cout16, sum16} !== exp) begin n_bad++; $display("FAIL dir_sum[%0d]: got %h expected %h", i, {cout16, sum16}, exp); end
      $display("dir op %0d: %h + %h + %b -> cout=%b sum=%h (lat %0d)", i, ta[i], tb[i], tc[i], cout16, sum16, lat);
      ack16();
      n_cmp++; if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
        n_bad++; $display("FAIL dir_handshake[%0d]: got vld=%b rdy=%b expected 0/1", i, out_valid16, in_ready16);
      end
    end
  endtask

  task automatic test_backpressure16();
    bit ok; int lat; logic [15:0] av, bv; logic cv; logic [16:0] exp;
    av = 16'($urandom); bv = 16'($urandom); cv = 1'($urandom);
    exp = ref16(av, bv, cv);
    start16(av, bv, cv, ok);
    wait16(lat);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL bp_latency: got %0d expected 4", lat); end
    in_valid16 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom);
      @(posedge clk); #1;
      n_cmp++; if (out_valid16 !== 1'b1 || in_ready16 !== 1'b0 || {cout16, sum16} !== exp) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b res=%h expected 1/0/%h", i, out_valid16, in_ready16, {cout16, sum16}, exp);
      end
    end
    in_valid16 = 1'b0;
    ack16();
    n_cmp++; if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1 || {cout16, sum16} !== exp) begin
      n_bad++; $display("FAIL bp_release: got vld=%b rdy=%b res=%h expected 0/1/%h", out_valid16, in_ready16, {cout16, sum16}, exp);
    end
    @(posedge clk); #1;
    n_cmp++; if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
      n_bad++; $display("FAIL bp_no_accept: got vld=%b rdy=%b expected 0/1", out_valid16, in_ready16);
    end
    $display("backpressure op: %h + %h + %b -> %h held 5 cycles", av, bv, cv, exp);
  endtask

  task automatic test_random16();
    for (int i = 0; i < 40; i++) begin
      bit ok; int lat; logic [15:0] av, bv; logic cv; logic [16:0] exp;
      av = 16'($urandom); cv = 1'($urandom);
      bv = ($urandom_range(3) == 0) ? ~av : 16'($urandom);
      exp = ref16(av, bv, cv);
      start16(av, bv, cv, ok);
      wait16(lat);
      repeat ($urandom_range(3)) begin @(posedge clk); #1; end
      n_cmp++; if (!ok || lat !== 4 || {cout16, sum16} !== exp) begin
        n_bad++; $display("FAIL rnd[%0d]: got ok=%b lat=%0d res=%h expected 1/4/%h", i, ok, lat, {cout16, sum16}, exp);
      end
      $display("rnd op %0d: %h + %h + %b -> %h", i, av, bv, cv, {cout16, sum16});
      ack16();
    end
  endtask

  task automatic test_reset_midrun16();
    bit ok; int lat; logic [16:0] exp;
    start16(16'h1234, 16'h4321, 1'b0, ok);
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n16 = 1'b0;
    #1;
    n_cmp++; if (out_valid16 !== 1'b0 || in_ready16 !== 1'b0 || {cout16, sum16} !== 17'h0) begin
      n_bad++; $display("FAIL midrun_reset: got vld=%b rdy=%b res=%h expected 0/0/0", out_valid16, in_ready16, {cout16, sum16});
    end
    @(posedge clk); #1;
    rst_n16 = 1'b1;
    #1;
    n_cmp++; if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0) begin
      n_bad++; $display("FAIL midrun_release: got rdy=%b vld=%b expected 1/0", in_ready16, out_valid16);
    end
    @(posedge clk); #1;
    exp = ref16(16'h0001, 16'h0001, 1'b0);
    start16(16'h0001, 16'h0001, 1'b0, ok);
    wait16(lat);
    n_cmp++; if (!ok || lat !== 4 || {cout16, sum16} !== exp) begin
      n_bad++; $display("FAIL midrun_fresh: got ok=%b lat=%0d res=%h expected 1/4/%h", ok, lat, {cout16, sum16}, exp);
    end
    $display("after mid-run reset: 0001 + 0001 -> %h", {cout16, sum16});
    ack16();
  endtask

  task automatic test_width4();
    bit ok; int lat; int errs_before;
    start4(4'hF, 4'hF, 1'b1, ok);
    wait4(lat);
    n_cmp++; if (!ok || lat !== 1) begin n_bad++; $display("FAIL w4_latency: got ok=%b lat=%0d expected 1/1", ok, lat); end
    n_cmp++; if ({cout4, sum4} !== ref4(4'hF, 4'hF, 1'b1)) begin
      n_bad++; $display("FAIL w4_FF1: got %h expected %h", {cout4, sum4}, ref4(4'hF, 4'hF, 1'b1));
    end
    $display("w4 op: F + F + 1 -> cout=%b sum=%h", cout4, sum4);
    ack4();
    errs_before = n_bad;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          logic [4:0] exp;
          exp = ref4(4'(x), 4'(y), 1'(c));
          start4(4'(x), 4'(y), 1'(c), ok);
          wait4(lat);
          n_cmp++; if (!ok || lat !== 1 || {cout4, sum4} !== exp) begin
            n_bad++; $display("FAIL w4_sweep %h+%h+%0d: got ok=%b lat=%0d res=%h expected 1/1/%h", x, y, c, ok, lat, {cout4, sum4}, exp);
          end
          ack4();
        end
      end
    end
    $display("w4 sweep: 512 operations, %0d bad", n_bad - errs_before);
  endtask

  initial begin
    clk = 1'b0;
    rst_n16 = 1'b0; in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    rst_n4 = 1'b0;  in_valid4 = 1'b0;  out_ready4 = 1'b0;  a4 = '0;  b4 = '0;  cin4 = 1'b0;
    test_reset();
    test_directed16();
    test_backpressure16();
    test_random16();
    test_reset_midrun16();
    test_width4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
